quad_input_filter: RTL and testbench
====================================

# quad_input_filter

Input-conditioning stage that sits directly upstream of the rotary encoder recoder in the rotation counter. It synchronizes the two raw quadrature encoder lines into the `clk` domain and debounces each one independently. It then presents clean `q_a`/`q_b` levels to the recoder, so that contact bounce cannot create false `quad_ctl` transitions or spurious error states in the rotation counter FSM. The stage also reports a one-cycle change strobe and an optional count of rejected glitches.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flip-flops in each synchronizer chain; legal range ≥ 2.
- `DB_CYCLES`, default 16: consecutive cycles a new level must persist before it is accepted; legal range ≥ 1.
- `GLITCH_W`, default 8: width of `glitch_count`.

Ports:
- `clk`, input, 1: system clock. This is the only clock in the block.
- `rst`, input, 1: reset, synchronous and active-high.
- `q_a_raw`, input, 1: encoder channel A, asynchronous to `clk`.
- `q_b_raw`, input, 1: encoder channel B, asynchronous to `clk`.
- `q_a`, output, 1: filtered channel A, registered.
- `q_b`, output, 1: filtered channel B, registered.
- `chg`, output, 1: pulse high for one cycle when `q_a` and/or `q_b` takes a new value.
- `glitch_count`, output, `GLITCH_W`: saturating count of rejected glitches.

## Operation

- Each channel has its own `SYNC_STAGES` flip-flop chain. Only the last stage of the chain (`s_x`) is used downstream.
- Each channel has a stable counter, `ceil(log2(DB_CYCLES+1))` bits wide, and a filtered output register `q_x`.
- Per channel, per clock edge (no reset asserted):
  - `s_x == q_x`: clear the counter.
  - `s_x != q_x` and counter `== DB_CYCLES-1`: set `q_x <= s_x` and clear the counter.
  - `s_x != q_x` otherwise: increment the counter.
- Abort (glitch): the counter is nonzero and `s_x == q_x` on this edge. The pending change is discarded.
- `glitch_count` adds the number of channels that abort on the same edge (0, 1 or 2). It saturates at `2^GLITCH_W-1` and never wraps.
- `chg` is registered. It is 1 in exactly the cycles in which `q_a` or `q_b` first shows a new value. If both channels change on the same edge, `chg` gives one pulse, not two.
- Each channel is a two-state machine, IDLE (counter = 0) and QUALIFY (counter > 0):
  - IDLE → QUALIFY on a mismatch, when `DB_CYCLES > 1`.
  - QUALIFY → IDLE on accept or on abort.
  - With `DB_CYCLES == 1`, the first mismatch is accepted immediately.
- There is no cross-channel check; illegal A/B sequences are detected downstream.

## Timing

- Reset values, applied on the first `clk` edge with `rst`=1:
  - all synchronizer flops, `q_a`, `q_b`, `chg` = 0;
  - both counters = 0;
  - `glitch_count` = 0.
- Reset mid-qualification discards the pending change. If a raw line is 1 after reset, the matching output rises after the full latency measured from the first edge with `rst`=0.
- Latency: a raw level that is stable before edge k appears on `q_x`, with `chg`=1, after edge k+`SYNC_STAGES`+`DB_CYCLES`-1. Defaults give 18 cycles.
- Minimum accepted pulse width is `DB_CYCLES` cycles as seen at the synchronizer output. Shorter pulses never reach `q_x`.
- A new mismatch that starts right after an accept begins a fresh count from zero.
- Outputs are glitch-free registered levels. Raw inputs may change at any time relative to `clk`.

## Configuration

- `QUAD_GLITCH_CNT_EN` defined: the glitch counter logic is built and `glitch_count` behaves as described above.
- `QUAD_GLITCH_CNT_EN` undefined: no counter logic is built and `glitch_count` is tied to 0. The port stays present, and filtering and `chg` are unchanged.

## Test plan

All scenarios use default parameters.

1. Reset: hold `rst`=1 for 3 cycles with `q_a_raw`=`q_b_raw`=1, then release → `q_a`/`q_b`/`chg`/`glitch_count` read 0 during reset; both outputs rise together 18 cycles after release with a single `chg` pulse.
2. Clean step: `q_a_raw` goes 0→1 before edge k → `q_a`=1 and `chg`=1 only after edge k+17; `q_b` unchanged; `glitch_count` stays 0.
3. Bounce: `q_a_raw` shows a 5-cycle high pulse, then settles low → `q_a` stays 0 and `glitch_count`=1.
   - Repeat with 15-cycle and 16-cycle pulses: the 15-cycle pulse is rejected; the 16-cycle pulse is accepted.
4. Full quadrature sequence: drive A/B as 00→01→11→10→00, holding each step 40 cycles → outputs replay the same sequence delayed by 18 cycles, with 4 `chg` pulses and 0 glitches.
5. Saturation (macro defined): inject 300 separate 3-cycle pulses → `glitch_count`=255 and it holds there. Macro undefined → `glitch_count`=0 throughout.
6. Reset mid-qualify: assert `rst` for 1 cycle, 10 cycles into a pending 0→1 on `q_b_raw` held high → `q_b` rises 18 cycles after `rst` deasserts; no `chg` pulse occurs during reset.

Source files
------------

// File: rtl/quad_input_filter.sv
// quad_input_filter: synchronizes and debounces the two raw quadrature lines
// (A, B) before they reach the rotary encoder recoder.
// Each channel has a SYNC_STAGES-deep synchronizer. After it, a debounce FSM
// only accepts a new level once it has persisted for DB_CYCLES consecutive
// cycles.
// chg pulses for one cycle whenever either filtered output takes a new value.
// Optional feature macro: QUAD_GLITCH_CNT_EN. When it is defined, glitch_count
// is a saturating count of aborted qualifications. When it is undefined,
// glitch_count is tied to 0.

// Per-channel synchronizer + debounce lane.
module quad_filter_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic q,
    output logic accept,
    output logic abort
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {IDLE, QUALIFY} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   mismatch;
    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   q_nxt;

    // Synchronizer chain; only the last flop feeds the filter.
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    assign s        = sync[SYNC_STAGES-1];
    assign mismatch = s ^ q;

    // State, stable counter and filtered output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
        end
    end

    // Next state: count consecutive mismatches.
    // Accept on the DB_CYCLES-th mismatch; drop the count on any match.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        case (state)
            IDLE: begin
                if (mismatch) begin
                    if (cnt == CNT_LAST) begin
                        // Only reachable with DB_CYCLES == 1: accept at once.
                        q_nxt = s;
                    end else begin
                        state_nxt = QUALIFY;
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end
            QUALIFY: begin
                if (!mismatch) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    q_nxt     = s;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: accept strobe for chg, abort strobe for the glitch counter.
    always_comb begin
        accept = mismatch && (cnt == CNT_LAST);
        abort  = (state == QUALIFY) && !mismatch;
    end
endmodule

module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                q_a_raw,
    input  logic                q_b_raw,
    output logic                q_a,
    output logic                q_b,
    output logic                chg,
    output logic [GLITCH_W-1:0] glitch_count
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] raw_vec;
    logic [NUM_LANES-1:0] q_vec;
    logic [NUM_LANES-1:0] acc_vec;
    logic [NUM_LANES-1:0] abort_vec;

    assign raw_vec = {q_b_raw, q_a_raw};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        quad_filter_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_vec[i]),
            .q     (q_vec[i]),
            .accept(acc_vec[i]),
            .abort (abort_vec[i])
        );
    end

    assign q_a = q_vec[0];
    assign q_b = q_vec[1];

    // One chg pulse per edge on which either output changes, even if both do.
    always_ff @(posedge clk) begin
        if (rst) chg <= 1'b0;
        else     chg <= |acc_vec;
    end

`ifdef QUAD_GLITCH_CNT_EN
    localparam int GW1 = GLITCH_W + 1;

    logic [GLITCH_W-1:0] gcnt;
    logic [GLITCH_W:0]   gsum;

    // One extra bit catches overflow so the count clamps instead of wrapping.
    always_comb begin
        gsum = {1'b0, gcnt} + GW1'(abort_vec[0]) + GW1'(abort_vec[1]);
    end

    // Saturating glitch counter.
    always_ff @(posedge clk) begin
        if (rst)                 gcnt <= '0;
        else if (gsum[GLITCH_W]) gcnt <= '1;
        else                     gcnt <= gsum[GLITCH_W-1:0];
    end

    assign glitch_count = gcnt;
`else
    logic unused_abort;
    assign unused_abort = ^abort_vec;
    assign glitch_count = '0;
`endif
endmodule

// File: tb/tb_quad_input_filter.sv
// Bench for quad_input_filter at default parameters. It runs directed
// scenarios plus a random phase, and checks every cycle against a run-length
// reference model.
module tb_quad_input_filter;
    localparam int SYNC = 2;
    localparam int DB   = 16;
    localparam int GW   = 8;
    localparam int GMAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          q_a_raw = 1'b0;
    logic          q_b_raw = 1'b0;
    logic          q_a, q_b, chg;
    logic [GW-1:0] glitch_count;

    always #5 clk = ~clk;

    quad_input_filter #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .GLITCH_W(GW)) dut (
        .clk         (clk),
        .rst         (rst),
        .q_a_raw     (q_a_raw),
        .q_b_raw     (q_b_raw),
        .q_a         (q_a),
        .q_b         (q_b),
        .chg         (chg),
        .glitch_count(glitch_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: raw delay line, current output and mismatch run length.
    int pipe[2][SYNC];
    int mq[2];
    int run[2];
    int mchg = 0;
    int mgc  = 0;
    int chg_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int raw[2];
        int acc;
        int s;
        raw[0] = int'(q_a_raw);
        raw[1] = int'(q_b_raw);
        acc = 0;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int j = 0; j < SYNC; j++) pipe[c][j] = 0;
                mq[c]  = 0;
                run[c] = 0;
            end
            mgc = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                s = pipe[c][SYNC-1];
                if (s != mq[c]) begin
                    run[c]++;
                    if (run[c] == DB) begin
                        mq[c]  = s;
                        run[c] = 0;
                        acc    = 1;
                    end
                end else begin
                    if (run[c] > 0 && mgc < GMAX) mgc++;
                    run[c] = 0;
                end
                for (int j = SYNC - 1; j > 0; j--) pipe[c][j] = pipe[c][j-1];
                pipe[c][0] = raw[c];
            end
        end
        mchg = acc;
    endtask

    function automatic int exp_gc(input int v);
`ifdef QUAD_GLITCH_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // One clock: update model at the edge, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("q_a", q_a, mq[0]);
        chk("q_b", q_b, mq[1]);
        chk("chg", chg, mchg);
        chk("glitch_count", glitch_count, exp_gc(mgc));
        if (chg === 1'b1) chg_seen++;
    endtask

    initial begin
        int n;
        int hi;
        int g0;
        int hold[2];
        logic [1:0] seq[5];
        int wid[3];

        // 1. Reset with both raw lines high.
        rst = 1'b1; q_a_raw = 1'b1; q_b_raw = 1'b1;
        repeat (3) tick();
        chk("rst_outs", {q_a, q_b, chg}, 0);
        chk("rst_gc", glitch_count, 0);
        rst = 1'b0;
        chg_seen = 0;
        n = 0;
        while (q_a !== 1'b1 && n < 100) begin tick(); n++; end
        chk("rst_lat", n, 18);
        chk("rst_qb_together", q_b, 1);
        repeat (5) tick();
        chk("rst_chg_pulses", chg_seen, 1);

        // 2. Clean step on A.
        q_a_raw = 1'b0; q_b_raw = 1'b0;
        repeat (30) tick();
        q_a_raw = 1'b1;
        n = 0;
        while (q_a !== 1'b1 && n < 100) begin tick(); n++; end
        chk("step_lat", n, 18);
        chk("step_qb", q_b, 0);
        chk("step_gc", glitch_count, 0);

        // 3. Bounce pulses of 5, 15 and 16 cycles on A.
        q_a_raw = 1'b0;
        repeat (30) tick();
        wid[0] = 5; wid[1] = 15; wid[2] = 16;
        for (int p = 0; p < 3; p++) begin
            g0 = mgc;
            q_a_raw = 1'b1;
            hi = 0;
            repeat (wid[p]) begin tick(); if (q_a === 1'b1) hi = 1; end
            q_a_raw = 1'b0;
            repeat (40) begin tick(); if (q_a === 1'b1) hi = 1; end
            chk($sformatf("bounce%0d_seen", wid[p]), hi, (wid[p] >= DB) ? 1 : 0);
            chk($sformatf("bounce%0d_gc", wid[p]), glitch_count,
                exp_gc(g0 + ((wid[p] >= DB) ? 0 : 1)));
            chk($sformatf("bounce%0d_qa_final", wid[p]), q_a, 0);
        end

        // 4. Full quadrature cycle, A is the upper bit of each step.
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10; seq[4] = 2'b00;
        g0 = mgc;
        chg_seen = 0;
        for (int st = 1; st < 5; st++) begin
            {q_a_raw, q_b_raw} = seq[st];
            repeat (17) tick();
            chk("quad_early", {q_a, q_b}, seq[st-1]);
            tick();
            chk("quad_late", {q_a, q_b}, seq[st]);
            repeat (22) tick();
        end
        chk("quad_chg_pulses", chg_seen, 4);
        chk("quad_gc", glitch_count, exp_gc(g0));

        // 5. Saturation: 300 short pulses on A.
        repeat (300) begin
            q_a_raw = 1'b1;
            repeat (3) tick();
            q_a_raw = 1'b0;
            repeat (5) tick();
        end
        chk("sat_gc", glitch_count, exp_gc(GMAX));
        repeat (10) tick();
        chk("sat_hold", glitch_count, exp_gc(GMAX));

        // 6. Reset in the middle of a pending B rise.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        q_b_raw = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("rst6_chg", chg, 0);
        chk("rst6_qb", q_b, 0);
        rst = 1'b0;
        n = 0;
        while (q_b !== 1'b1 && n < 100) begin tick(); n++; end
        chk("rst6_lat", n, 18);

        // 7. Random hold lengths straddling the debounce window.
        hold[0] = 0; hold[1] = 0;
        repeat (3000) begin
            if (hold[0] == 0) begin
                q_a_raw = $urandom_range(1, 0);
                hold[0] = $urandom_range(30, 1);
            end
            if (hold[1] == 0) begin
                q_b_raw = $urandom_range(1, 0);
                hold[1] = $urandom_range(30, 1);
            end
            hold[0]--; hold[1]--;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
